// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      F_IDLE,
      F_FETCH,
      F_HOLD,
      F_DISCARD
   } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush wins over push/pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues single-outstanding reads and
// queues fetched words for the decoder; redirects flush and restart fetch.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_data,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t              state, state_n;
   logic [ADDR_W-1:0]         fetch_pc, fetch_pc_n;
   logic [ADDR_W-1:0]         req_addr, req_addr_n;
   logic                      push, pop, flush;
   logic [CW-1:0]             count;
   logic [ADDR_W+WORD_W-1:0]  head;
   int                        occ_n;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({req_addr, mem_data}),
      .rdata (head),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= F_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         req_addr <= req_addr_n;
      end
   end

   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      req_addr_n = req_addr;
      push       = 1'b0;
      flush      = 1'b0;
      pop        = instr_valid && instr_ready;
      occ_n      = int'(count) - (pop ? 1 : 0);
      // Redirect overrides push/pop; an unacked request must still be drained.
      if (redirect) begin
         flush      = 1'b1;
         pop        = 1'b0;
         fetch_pc_n = redirect_pc;
         if ((state == F_FETCH || state == F_DISCARD) && !mem_ack) begin
            state_n = F_DISCARD;
         end else begin
            state_n    = F_FETCH;
            req_addr_n = redirect_pc;
         end
      end else begin
         case (state)
            F_IDLE: begin
               state_n    = F_FETCH;
               req_addr_n = fetch_pc;
            end
            F_FETCH: begin
               if (mem_ack) begin
                  push       = 1'b1;
                  fetch_pc_n = fetch_pc + ADDR_W'(1);
                  req_addr_n = fetch_pc + ADDR_W'(1);
                  if (occ_n + 1 == DEPTH) state_n = F_HOLD;
               end
            end
            F_HOLD: begin
               if (occ_n < DEPTH) begin
                  state_n    = F_FETCH;
                  req_addr_n = fetch_pc;
               end
            end
            F_DISCARD: begin
               if (mem_ack) begin
                  state_n    = F_FETCH;
                  req_addr_n = fetch_pc;
               end
            end
            default: state_n = F_IDLE;
         endcase
      end
   end

   assign mem_req     = (state == F_FETCH) || (state == F_DISCARD);
   assign mem_addr    = req_addr;
   assign instr_pc    = head[WORD_W +: ADDR_W];
   assign instr       = head[WORD_W-1:0];
   assign instr_valid = (count != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder with programmable ack
// delay, a decoder-side monitor, and a second instance built at RESET_PC=FFFE.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_data = '0;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;

   logic        w_req;
   logic [15:0] w_addr;
   logic        w_ack;
   logic [15:0] w_data;
   logic [15:0] w_instr;
   logic [15:0] w_pc;
   logic        w_valid;
   logic        w_ready = 1'b1;
   logic        w_redirect = 1'b0;
   logic [15:0] w_redirect_pc = '0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] wq[$];
   logic [31:0] exp_w;
   int          ack_delay = 0;
   bit          ack_en = 1'b0;
   int          wait_cnt = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(2)) u_wrap (
      .clk(clk), .rst_n(rst_n), .mem_req(w_req), .mem_addr(w_addr),
      .mem_ack(w_ack), .mem_data(w_data), .instr(w_instr), .instr_pc(w_pc),
      .instr_valid(w_valid), .instr_ready(w_ready),
      .redirect(w_redirect), .redirect_pc(w_redirect_pc)
   );

   assign w_ack  = w_req;
   assign w_data = memf(w_addr);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Memory: acks after ack_delay idle cycles of a held request.
   initial begin
      forever begin
         tick();
         if (mem_req && ack_en) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               mem_data = memf(mem_addr);
               wait_cnt = 0;
            end else begin
               mem_ack  = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Decoder-side monitor: every consumed word must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got pc=%h instr=%h, expected none", instr_pc, instr);
         end else begin
            exp_w = sb.pop_front();
            if ({instr_pc, instr} !== exp_w) begin
               errors++;
               $display("FAIL word: got pc=%h instr=%h, expected pc=%h instr=%h",
                        instr_pc, instr, exp_w[31:16], exp_w[15:0]);
            end
         end
      end
   end

   task automatic do_reset;
      rst_n       = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'b0;
      sb.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      ack_en = 1'b0;
      rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      repeat (3) tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
      checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
      checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      rst_n = 1'b1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_cycle_req: got %b expected 0", mem_req); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected 1/0000", mem_req, mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_valid: got %b expected 0", instr_valid); end
   endtask

   task automatic test_stream;
      int n;
      ack_delay = 0; ack_en = 1'b1;
      do_reset();
      instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) sb.push_back({16'(i), memf(16'(i))});
      n = 0;
      while (sb.size() != 0 && n < 50) begin tick(); n++; end
      checks++; if (n !== 10) begin errors++; $display("FAIL stream_rate: got %0d cycles expected 10", n); end
      instr_ready = 1'b0;
   endtask

   task automatic test_hold;
      int n;
      ack_delay = 0; ack_en = 1'b1;
      do_reset();
      repeat (5) tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b expected 0", mem_req); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("FAIL hold_head: got v=%b pc=%h expected 1/0000", instr_valid, instr_pc); end
      for (int i = 0; i < 4; i++) sb.push_back({16'(i), memf(16'(i))});
      instr_ready = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL hold_resume: got req=%b addr=%h expected 1/0002", mem_req, mem_addr); end
      n = 0;
      while (sb.size() != 0 && n < 20) begin tick(); n++; end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL hold_drain: got %0d left expected 0", sb.size()); end
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_pending;
      int n;
      ack_delay = 3; ack_en = 1'b1;
      do_reset();
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) sb.push_back({16'(i), memf(16'(i))});
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr === 16'h0005) && n < 60) begin tick(); n++; end
      checks++; if (n >= 60) begin errors++; $display("FAIL rp_reach5: got timeout expected req to 0005"); end
      tick();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rp_predrain: got %0d left expected 0", sb.size()); end
      redirect = 1'b1; redirect_pc = 16'h0040;
      sb.push_back({16'h0040, memf(16'h0040)});
      sb.push_back({16'h0041, memf(16'h0041)});
      tick();
      redirect = 1'b0;
      n = 0;
      while (mem_addr === 16'h0005 && n < 10) begin
         checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL rp_discard: got req=%b valid=%b expected 1/0", mem_req, instr_valid); end
         tick(); n++;
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL rp_hold_cycles: got %0d expected 2", n); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL rp_target: got req=%b addr=%h expected 1/0040", mem_req, mem_addr); end
      n = 0;
      while (sb.size() != 0 && n < 40) begin tick(); n++; end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rp_drain: got %0d left expected 0", sb.size()); end
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_ack;
      int n;
      ack_delay = 0; ack_en = 1'b1;
      do_reset();
      instr_ready = 1'b1;
      tick(); tick(); #1;
      checks++; if (mem_ack !== 1'b1 || instr_valid !== 1'b1) begin errors++; $display("FAIL ra_setup: got ack=%b valid=%b expected 1/1", mem_ack, instr_valid); end
      redirect = 1'b1; redirect_pc = 16'h0080;
      sb.push_back({16'h0080, memf(16'h0080)});
      sb.push_back({16'h0081, memf(16'h0081)});
      tick();
      redirect = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: got valid=%b expected 0", instr_valid); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0080) begin errors++; $display("FAIL ra_target: got req=%b addr=%h expected 1/0080", mem_req, mem_addr); end
      n = 0;
      while (sb.size() != 0 && n < 20) begin tick(); n++; end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL ra_drain: got %0d left expected 0", sb.size()); end
      instr_ready = 1'b0;
   endtask

   task automatic test_wrap;
      int n;
      do_reset();
      wq.delete();
      wq.push_back({16'hFFFE, memf(16'hFFFE)});
      wq.push_back({16'hFFFF, memf(16'hFFFF)});
      wq.push_back({16'h0000, memf(16'h0000)});
      n = 0;
      while (wq.size() != 0 && n < 20) begin
         tick(); n++;
         if (w_valid) begin
            exp_w = wq.pop_front();
            checks++;
            if ({w_pc, w_instr} !== exp_w) begin errors++; $display("FAIL wrap_word: got pc=%h instr=%h expected pc=%h instr=%h", w_pc, w_instr, exp_w[31:16], exp_w[15:0]); end
         end
      end
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL wrap_timeout: got %0d left expected 0", wq.size()); end
   endtask

   task automatic test_reset_mid;
      int n;
      ack_delay = 0; ack_en = 1'b1;
      do_reset();
      repeat (4) tick();
      checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rm_full: got valid=%b req=%b expected 1/0", instr_valid, mem_req); end
      ack_delay = 3;
      sb.push_back({16'h0000, memf(16'h0000)});
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      #1;
      n = 0;
      while (mem_ack !== 1'b1 && n < 10) begin tick(); #1; n++; end
      checks++; if (mem_ack !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL rm_pending: got ack=%b req=%b addr=%h expected 1/1/0002", mem_ack, mem_req, mem_addr); end
      rst_n = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", mem_req); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rm_addr: got %h expected 0000", mem_addr); end
      checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin errors++; $display("FAIL rm_instr: got %h/%h expected 0000/0000", instr, instr_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", instr_valid); end
      rst_n = 1'b1;
      ack_delay = 0;
      sb.push_back({16'h0000, memf(16'h0000)});
      sb.push_back({16'h0001, memf(16'h0001)});
      instr_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 20) begin tick(); n++; end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rm_restart: got %0d left expected 0", sb.size()); end
      instr_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_redirect_pending();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
